cordic2_arbiter: RTL and testbench

- Shares one pipelined cordic2 core between NREQ requesters, e.g. several custom-instruction ports.
- Each cycle, a round-robin arbiter grants at most one request and drives its theta into the core.
- A tag/valid shift register of depth LATENCY tracks each grant, so every core result returns to the requester that issued it.
- The core has no handshake: fixed latency, one operand accepted per cycle. All sequencing lives in this block.

---
 rtl/cordic2_pkg.sv | 16 +
 rtl/cordic2_arbiter_rr.sv | 38 +++
 rtl/cordic2_arbiter.sv | 93 +++++++++
 tb/tb_cordic2_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic2_pkg.sv
// Shared constants and tag helpers for the cordic2 core and its request arbiter.
package cordic2_pkg;

  localparam int CORDIC_WIDTH   = 32;
  localparam int CORDIC_LATENCY = 16;
  localparam int CORDIC_NREQ    = 2;

  // Tag width for a given requester count; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W = tag_w(CORDIC_NREQ);
  typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/cordic2_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  // Rotate so that bit 0 is the requester at ptr.
  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    // Descending scan: the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IW + 1)'(k);
      end
    end
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/cordic2_arbiter.sv
// Shares one fixed-latency cordic2 core between NREQ requesters; a tag pipeline
// routes each result back to the requester that issued it.
module cordic2_arbiter
  import cordic2_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int WIDTH   = CORDIC_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]      req_theta,
  output logic [NREQ-1:0]                 req_ready,
  output logic [NREQ-1:0]                 resp_valid,
  output logic [WIDTH-1:0]                resp_result,
  output logic [WIDTH-1:0]                core_theta,
  input  logic [WIDTH-1:0]                core_result,
  output logic                            busy,
  output logic [$clog2(LATENCY+1)-1:0]    inflight
);

  localparam int TW = tag_w(NREQ);
  localparam int CW = $clog2(LATENCY + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("cordic2_arbiter: NREQ must be in 2..8");
  end
  if (WIDTH != CORDIC_WIDTH) begin : g_chk_width
    $error("cordic2_arbiter: WIDTH must match the core width");
  end
  if (LATENCY < 1) begin : g_chk_lat
    $error("cordic2_arbiter: LATENCY must be at least 1");
  end

  logic [TW-1:0]              rr_ptr;
  logic [TW-1:0]              gnt_idx;
  logic [TW-1:0]              nxt_ptr;
  logic [NREQ-1:0]            gnt;
  logic                       gnt_any;
  logic                       retire;
  logic [LATENCY-1:0]         vld_pipe;
  logic [LATENCY-1:0][TW-1:0] tag_pipe;

  rr_arbiter #(.N(NREQ), .IW(TW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Grant is suppressed while reset is held so nothing is promised that won't issue.
  assign req_ready = reset ? gnt : '0;
  assign nxt_ptr   = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
  assign retire    = vld_pipe[LATENCY-1];
  assign busy      = (inflight != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      core_theta  <= '0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      inflight    <= '0;
    end else begin
      if (gnt_any) begin
        core_theta <= req_theta[gnt_idx];
        rr_ptr     <= nxt_ptr;
      end
      // Stage LATENCY-1 lines up with core_result for the same operand.
      vld_pipe[0] <= gnt_any;
      tag_pipe[0] <= gnt_idx;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      resp_valid <= '0;
      if (retire) begin
        resp_valid[tag_pipe[LATENCY-1]] <= 1'b1;
        resp_result                     <= core_result;
      end
      case ({gnt_any, retire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic2_arbiter.sv
// Bench for cordic2_arbiter: a 2-requester and a 3-requester instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_cordic2_arbiter;
  localparam int LAT = 16;
  localparam int W   = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] reqv;
  logic [2:0][W-1:0] thv;

  logic [1:0] a_rdy, a_rv;
  logic [W-1:0] a_res, a_ct, a_cr;
  logic a_busy;
  logic [4:0] a_inf;
  logic [2:0] b_rdy, b_rv;
  logic [W-1:0] b_res, b_ct, b_cr;
  logic b_busy;
  logic [4:0] b_inf;

  always #5 clk = ~clk;

  cordic2_arbiter #(.NREQ(2), .LATENCY(LAT), .WIDTH(W)) dut_a (
    .clk(clk), .reset(reset_n), .req_valid(reqv[1:0]), .req_theta(thv[1:0]),
    .req_ready(a_rdy), .resp_valid(a_rv), .resp_result(a_res),
    .core_theta(a_ct), .core_result(a_cr), .busy(a_busy), .inflight(a_inf));

  cordic2_arbiter #(.NREQ(3), .LATENCY(LAT), .WIDTH(W)) dut_b (
    .clk(clk), .reset(reset_n), .req_valid(reqv), .req_theta(thv),
    .req_ready(b_rdy), .resp_valid(b_rv), .resp_result(b_res),
    .core_theta(b_ct), .core_result(b_cr), .busy(b_busy), .inflight(b_inf));

  // Core model: core_theta is the core's input register, followed by LAT-1 stages.
  logic [W-1:0] ca_d [LAT-1];
  logic [W-1:0] cb_d [LAT-1];
  always @(posedge clk) begin
    ca_d[0] <= a_ct;
    cb_d[0] <= b_ct;
    for (int i = 1; i < LAT - 1; i++) begin
      ca_d[i] <= ca_d[i-1];
      cb_d[i] <= cb_d[i-1];
    end
  end
  assign a_cr = ~ca_d[LAT-2];
  assign b_cr = ~cb_d[LAT-2];

  // Reference model: each grant schedules a response LAT+1 cycles later.
  typedef struct {
    int           due;
    int           tag;
    logic [W-1:0] res;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int pa, pb, cyc, ga, gb, ea_inf, eb_inf;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] ea_rdy, ea_rv;
  logic [2:0] eb_rdy, eb_rv;
  logic [W-1:0] ea_res, eb_res, ea_ct, eb_ct;

  function automatic int arb(input int n, input int p, input logic [2:0] v);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (p + k) % n;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_eval();
    if (!reset_n) begin
      qa.delete(); qb.delete();
      pa = 0; pb = 0;
      ea_res = '0; eb_res = '0; ea_ct = '0; eb_ct = '0;
    end
    ga = reset_n ? arb(2, pa, {1'b0, reqv[1:0]}) : -1;
    gb = reset_n ? arb(3, pb, reqv) : -1;
    ea_rdy = (ga >= 0) ? 2'(1 << ga) : 2'b00;
    eb_rdy = (gb >= 0) ? 3'(1 << gb) : 3'b000;
    ea_rv = '0; ea_inf = qa.size();
    if (qa.size() != 0 && qa[0].due == cyc) begin
      ea_rv = 2'(1 << qa[0].tag); ea_res = qa[0].res; ea_inf--;
    end
    eb_rv = '0; eb_inf = qb.size();
    if (qb.size() != 0 && qb[0].due == cyc) begin
      eb_rv = 3'(1 << qb[0].tag); eb_res = qb[0].res; eb_inf--;
    end
  endtask

  task automatic model_commit();
    ent_t e;
    if (qa.size() != 0 && qa[0].due == cyc) void'(qa.pop_front());
    if (qb.size() != 0 && qb[0].due == cyc) void'(qb.pop_front());
    if (ga >= 0) begin
      e.due = cyc + LAT + 1; e.tag = ga; e.res = ~thv[ga];
      qa.push_back(e); pa = (ga + 1) % 2; ea_ct = thv[ga];
    end
    if (gb >= 0) begin
      e.due = cyc + LAT + 1; e.tag = gb; e.res = ~thv[gb];
      qb.push_back(e); pb = (gb + 1) % 3; eb_ct = thv[gb];
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    reset_n = 1'b0; reqv = '0;
    repeat (n) begin sample(); step(); end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reqv = 3'b011;
    thv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      sample();
      n_chk++;
      if (a_rdy !== '0 || a_rv !== '0 || a_busy !== 1'b0 || a_inf !== '0 || a_ct !== '0 || a_res !== '0) begin
        n_fail++;
        $display("FAIL reset_a k=%0d got rdy=%b rv=%b busy=%b inf=%0d ct=%h res=%h want all zero", k, a_rdy, a_rv, a_busy, a_inf, a_ct, a_res);
      end
      n_chk++;
      if (b_rdy !== '0 || b_rv !== '0 || b_busy !== 1'b0 || b_inf !== '0 || b_ct !== '0 || b_res !== '0) begin
        n_fail++;
        $display("FAIL reset_b k=%0d got rdy=%b rv=%b busy=%b inf=%0d ct=%h res=%h want all zero", k, b_rdy, b_rv, b_busy, b_inf, b_ct, b_res);
      end
      step();
    end
    reset_n = 1'b1; reqv = '0;
  endtask

  task automatic test_single();
    pulse_reset(2);
    reqv = 3'b001; thv[0] = 32'hbf7f0000;
    for (int k = 0; k < 20; k++) begin
      sample();
      n_chk++;
      if ({a_rdy, a_rv, a_res, a_ct, a_busy, a_inf} !== {ea_rdy, ea_rv, ea_res, ea_ct, (ea_inf != 0), 5'(ea_inf)}) begin
        n_fail++;
        $display("FAIL single_model_a k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, a_rdy, a_rv, a_res, a_inf, ea_rdy, ea_rv, ea_res, ea_inf);
      end
      n_chk++;
      if (a_rv !== ((k == 17) ? 2'b01 : 2'b00) || a_busy !== (k >= 1 && k <= 16)) begin
        n_fail++;
        $display("FAIL single_timing k=%0d got rv=%b busy=%b", k, a_rv, a_busy);
      end
      if (k == 17) begin
        n_chk++;
        if (a_res !== 32'h4080ffff) begin
          n_fail++;
          $display("FAIL single_result got %h want 4080ffff", a_res);
        end
      end
      step();
      reqv = '0;
    end
  endtask

  task automatic test_contention();
    int peak;
    peak = 0;
    pulse_reset(2);
    for (int k = 0; k < 26; k++) begin
      reqv = (k < 6) ? 3'b011 : 3'b000;
      thv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sample();
      n_chk++;
      if ({a_rdy, a_rv, a_res, a_ct, a_busy, a_inf} !== {ea_rdy, ea_rv, ea_res, ea_ct, (ea_inf != 0), 5'(ea_inf)}) begin
        n_fail++;
        $display("FAIL contention_model_a k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, a_rdy, a_rv, a_res, a_inf, ea_rdy, ea_rv, ea_res, ea_inf);
      end
      n_chk++;
      if ({b_rdy, b_rv, b_res, b_ct, b_busy, b_inf} !== {eb_rdy, eb_rv, eb_res, eb_ct, (eb_inf != 0), 5'(eb_inf)}) begin
        n_fail++;
        $display("FAIL contention_model_b k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, b_rdy, b_rv, b_res, b_inf, eb_rdy, eb_rv, eb_res, eb_inf);
      end
      if (k < 6) begin
        n_chk++;
        if (a_rdy !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL contention_grant k=%0d got %b", k, a_rdy);
        end
      end
      if (k >= 17 && k <= 22) begin
        n_chk++;
        if (a_rv !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL contention_resp k=%0d got %b", k, a_rv);
        end
      end
      if (int'(a_inf) > peak) peak = int'(a_inf);
      step();
    end
    n_chk++;
    if (peak != 6) begin
      n_fail++;
      $display("FAIL contention_peak got %0d want 6", peak);
    end
  endtask

  task automatic test_wrap_skip();
    logic seen1;
    seen1 = 1'b0;
    pulse_reset(2);
    for (int k = 0; k < 26; k++) begin
      reqv = (k < 8) ? 3'b101 : 3'b000;
      thv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sample();
      n_chk++;
      if ({b_rdy, b_rv, b_res, b_ct, b_busy, b_inf} !== {eb_rdy, eb_rv, eb_res, eb_ct, (eb_inf != 0), 5'(eb_inf)}) begin
        n_fail++;
        $display("FAIL wrap_model_b k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, b_rdy, b_rv, b_res, b_inf, eb_rdy, eb_rv, eb_res, eb_inf);
      end
      n_chk++;
      if ({a_rdy, a_rv, a_res, a_ct, a_busy, a_inf} !== {ea_rdy, ea_rv, ea_res, ea_ct, (ea_inf != 0), 5'(ea_inf)}) begin
        n_fail++;
        $display("FAIL wrap_model_a k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, a_rdy, a_rv, a_res, a_inf, ea_rdy, ea_rv, ea_res, ea_inf);
      end
      if (k < 8) begin
        n_chk++;
        if (b_rdy !== ((k % 2 == 0) ? 3'b001 : 3'b100)) begin
          n_fail++;
          $display("FAIL wrap_grant k=%0d got %b", k, b_rdy);
        end
      end
      seen1 = seen1 | b_rdy[1] | b_rv[1];
      step();
    end
    n_chk++;
    if (seen1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_skip got requester1 activity=%b want 0", seen1);
    end
  endtask

  task automatic test_reset_midflight();
    pulse_reset(2);
    for (int k = 0; k < 46; k++) begin
      reqv = (k < 4) ? 3'b011 : ((k == 25) ? 3'b010 : 3'b000);
      reset_n = (k != 5);
      thv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sample();
      n_chk++;
      if ({a_rdy, a_rv, a_res, a_ct, a_busy, a_inf} !== {ea_rdy, ea_rv, ea_res, ea_ct, (ea_inf != 0), 5'(ea_inf)}) begin
        n_fail++;
        $display("FAIL midrst_model_a k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, a_rdy, a_rv, a_res, a_inf, ea_rdy, ea_rv, ea_res, ea_inf);
      end
      n_chk++;
      if ({b_rdy, b_rv, b_res, b_ct, b_busy, b_inf} !== {eb_rdy, eb_rv, eb_res, eb_ct, (eb_inf != 0), 5'(eb_inf)}) begin
        n_fail++;
        $display("FAIL midrst_model_b k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, b_rdy, b_rv, b_res, b_inf, eb_rdy, eb_rv, eb_res, eb_inf);
      end
      if (k == 5 || k == 6) begin
        n_chk++;
        if (a_inf !== '0 || a_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_inflight k=%0d got inf=%0d busy=%b want 0", k, a_inf, a_busy);
        end
      end
      if (k >= 5 && k < 42) begin
        n_chk++;
        if (a_rv !== 2'b00) begin
          n_fail++;
          $display("FAIL midrst_stale k=%0d got rv=%b want 00", k, a_rv);
        end
      end
      if (k == 42) begin
        n_chk++;
        if (a_rv !== 2'b10) begin
          n_fail++;
          $display("FAIL midrst_fresh got rv=%b want 10", a_rv);
        end
      end
      step();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    pulse_reset(2);
    for (int k = 0; k < 60; k++) begin
      reqv = (k < 40) ? 3'b010 : 3'b000;
      thv[1] = $urandom;
      sample();
      n_chk++;
      if ({a_rdy, a_rv, a_res, a_ct, a_busy, a_inf} !== {ea_rdy, ea_rv, ea_res, ea_ct, (ea_inf != 0), 5'(ea_inf)}) begin
        n_fail++;
        $display("FAIL stream_model_a k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, a_rdy, a_rv, a_res, a_inf, ea_rdy, ea_rv, ea_res, ea_inf);
      end
      if (k >= 16 && k <= 40) begin
        n_chk++;
        if (a_inf !== 5'd16) begin
          n_fail++;
          $display("FAIL stream_sat k=%0d got inf=%0d want 16", k, a_inf);
        end
      end
      if (k >= 17 && k <= 56) begin
        n_chk++;
        if (a_rv !== 2'b10) begin
          n_fail++;
          $display("FAIL stream_resp k=%0d got rv=%b want 10", k, a_rv);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    pulse_reset(2);
    for (int k = 0; k < 140; k++) begin
      if (k < 120) begin
        reqv = 3'($urandom);
        reset_n = ($urandom_range(0, 49) != 0);
      end else begin
        reqv = '0;
        reset_n = 1'b1;
      end
      thv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sample();
      n_chk++;
      if ({a_rdy, a_rv, a_res, a_ct, a_busy, a_inf} !== {ea_rdy, ea_rv, ea_res, ea_ct, (ea_inf != 0), 5'(ea_inf)}) begin
        n_fail++;
        $display("FAIL random_model_a k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, a_rdy, a_rv, a_res, a_inf, ea_rdy, ea_rv, ea_res, ea_inf);
      end
      n_chk++;
      if ({b_rdy, b_rv, b_res, b_ct, b_busy, b_inf} !== {eb_rdy, eb_rv, eb_res, eb_ct, (eb_inf != 0), 5'(eb_inf)}) begin
        n_fail++;
        $display("FAIL random_model_b k=%0d got rdy=%b rv=%b res=%h inf=%0d want rdy=%b rv=%b res=%h inf=%0d", k, b_rdy, b_rv, b_res, b_inf, eb_rdy, eb_rv, eb_res, eb_inf);
      end
      step();
    end
  endtask

  initial begin
    reset_n = 1'b1; reqv = '0; thv = '0;
    cyc = 0; pa = 0; pb = 0;
    ea_res = '0; eb_res = '0; ea_ct = '0; eb_ct = '0;
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_contention();
    test_wrap_skip();
    test_reset_midflight();
    test_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
